// File: rtl/wb_master_lsu.sv
// Wishbone pipelined-mode load/store master: one outstanding access, lane alignment, load extension.
// Optional bus abort timer is enabled by defining WB_MASTER_TIMEOUT_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN ((`XLEN == 64) ? 3 : 2)
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES (`XLEN / 8)
`endif

module wb_master_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [`XLEN-1:0]                  req_addr_i,
  input  logic                              req_we_i,
  input  logic [1:0]                        req_size_i,
  input  logic                              req_unsigned_i,
  input  logic [`XLEN-1:0]                  req_wdata_i,
  output logic                              rsp_valid_o,
  output logic [`XLEN-1:0]                  rsp_rdata_o,
  output logic                              rsp_err_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  output logic                              we_o,
  output logic [`XLEN-`XLEN_GRAN-1:0]       adr_o,
  output logic [`XLEN_BYTES-1:0]            sel_o,
  output logic [`XLEN-1:0]                  dat_o,
  input  logic [`XLEN-1:0]                  dat_i,
  input  logic                              ack_i,
  input  logic                              err_i,
  input  logic                              stall_i
);

  localparam int unsigned Xlen = `XLEN;
  localparam int unsigned Gran = `XLEN_GRAN;
  localparam int unsigned NumBytes = `XLEN_BYTES;
  localparam int unsigned AdrW = Xlen - Gran;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AdrW-1:0]      adr_q, adr_d;
  logic [NumBytes-1:0]  sel_q, sel_d;
  logic [Xlen-1:0]      dat_q, dat_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [Xlen-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]           size_q, size_d;
  logic [Gran-1:0]      off_q, off_d;
  logic                 uns_q, uns_d;

  logic                 accept, misaligned, in_bus, done, timeout, rd_sign;
  logic [Gran-1:0]      req_off, align_mask;
  logic [NumBytes-1:0]  req_sel;
  logic [Xlen-1:0]      req_dat, rd_shift, rd_ext;

  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i & req_ready_o;
  assign req_off     = req_addr_i[Gran-1:0];
  assign in_bus      = (state_q == StReq) | (state_q == StWait);
  assign done        = in_bus & (ack_i | err_i | timeout);

  always_comb begin
    align_mask = '0;
    for (int unsigned i = 0; i < Gran; i++) begin
      align_mask[i] = (i < 32'(req_size_i));
    end
  end

  assign misaligned = (32'(req_size_i) > Gran) | (|(req_off & align_mask));

  // Lane selects cover 2^size bytes starting at the byte offset.
  always_comb begin
    req_sel = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      req_sel[b] = (b >= 32'(req_off)) && (b < 32'(req_off) + (32'd1 << req_size_i));
    end
  end

  always_comb begin
    case (req_size_i)
      2'd0:    req_dat = {NumBytes{req_wdata_i[7:0]}};
      2'd1:    req_dat = {(NumBytes / 2){req_wdata_i[15:0]}};
      2'd2:    req_dat = {(NumBytes / 4){req_wdata_i[31:0]}};
      default: req_dat = req_wdata_i;
    endcase
  end

  assign rd_shift = dat_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    rd_sign = rd_shift[7];
      2'd1:    rd_sign = rd_shift[15];
      2'd2:    rd_sign = rd_shift[31];
      default: rd_sign = rd_shift[Xlen-1];
    endcase
    rd_ext = '0;
    for (int unsigned i = 0; i < Xlen; i++) begin
      rd_ext[i] = (i < (32'd8 << size_q)) ? rd_shift[i] : (~uns_q & rd_sign);
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign cnt_d   = accept ? '0 : (in_bus ? cnt_q + 1'b1 : cnt_q);
  assign timeout = in_bus & ~ack_i & ~err_i & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = misaligned ? StResp : StReq;
      StReq: begin
        if (done)          state_d = StResp;
        else if (!stall_i) state_d = StWait;
      end
      StWait: if (done) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = req_we_i;
            adr_d  = req_addr_i[Xlen-1:Gran];
            sel_d  = req_sel;
            dat_d  = req_dat;
            size_d = req_size_i;
            off_d  = req_off;
            uns_d  = req_unsigned_i;
          end
        end
      end
      StReq, StWait: begin
        if (done) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_i | timeout;
          // Error beats ack when both arrive together.
          if (ack_i && !err_i && !timeout && !we_q) rsp_rdata_d = rd_ext;
        end else if (state_q == StReq && !stall_i) begin
          stb_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_wb_master_lsu.sv
// Scoreboarded random bench for wb_master_lsu (XLEN=32) with an in-bench Wishbone slave.
`timescale 1ns/1ps
module tb_wb_master_lsu;

  localparam int unsigned TimeoutCycles = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        cyc_o, stb_o, we_o;
  logic [29:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0, err_i = 1'b0, stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_master_lsu #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
    .stall_i(stall_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_r;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;

  // Slave configuration for the transaction in flight.
  int          s_stall = 0, s_delay = 0, stb_seen = 0, dcnt = 0;
  bit          s_err = 0, s_noack = 0, pend = 0, bus_exp = 0;
  logic [31:0] s_rdata = '0, e_dat = '0;
  logic [29:0] e_adr = '0;
  logic [3:0]  e_sel = '0;
  logic        e_we = 1'b0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc_cnt);
    end
  endtask

  always @(negedge clk_i) begin
    ack_i   = 1'b0;
    err_i   = 1'b0;
    stall_i = 1'b0;
    dat_i   = $urandom;
    if (!rst_ni) begin
      pend = 0;
    end else begin
      if (pend) begin
        if (dcnt == 0) begin
          pend = 0;
          if (s_err) err_i = 1'b1;
          else begin ack_i = 1'b1; dat_i = s_rdata; end
        end else dcnt--;
      end
      if (cyc_o) check("cyc_allowed", {31'b0, bus_exp}, 32'd1);
      if (stb_o) begin
        stb_seen++;
        check("cyc_with_stb", {31'b0, cyc_o}, 32'd1);
        check("adr_o", {2'b00, adr_o}, {2'b00, e_adr});
        check("sel_o", {28'b0, sel_o}, {28'b0, e_sel});
        check("dat_o", dat_o, e_dat);
        check("we_o", {31'b0, we_o}, {31'b0, e_we});
        if (s_stall > 0) begin
          stall_i = 1'b1;
          s_stall--;
        end else if (!s_noack) begin
          if (s_delay < 0) begin
            if (s_err) err_i = 1'b1;
            else begin ack_i = 1'b1; dat_i = s_rdata; end
          end else begin
            pend = 1;
            dcnt = s_delay;
          end
        end
      end else if (!cyc_o && $urandom_range(0, 3) == 0) begin
        ack_i = 1'b1;  // stray ack outside a bus cycle must be ignored
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=none at cycle %0d", cyc_cnt);
      end else begin
        mon_r = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, mon_r.rdata);
        check("rsp_err", {31'b0, rsp_err_o}, {31'b0, mon_r.err});
        check("rsp_cycle", cyc_cnt, mon_r.cyc);
      end
    end
  end

  task automatic recover();
    rst_ni = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [31:0] bus_rd,
                       input int stall, input int delay, input bit berr,
                       input bit use_lit, input logic [31:0] lit);
    rsp_t        r;
    int unsigned nb, off, lat;
    bit          ok;
    logic [31:0] v, mask;
    int          guard;
    guard = 0;
    @(negedge clk_i);
    while (!req_ready_o && guard < 50) begin @(negedge clk_i); guard++; end
    check("req_ready", {31'b0, req_ready_o}, 32'd1);
    if (!req_ready_o) begin recover(); return; end
    nb  = 32'd1 << size;
    off = addr % 4;
    ok  = (size <= 2) && (addr % nb == 0);
    bus_exp = ok;
    e_adr   = addr[31:2];
    e_sel   = 4'(((32'd1 << nb) - 1) << off);
    e_we    = we;
    case (size)
      2'd0:    e_dat = {4{wdata[7:0]}};
      2'd1:    e_dat = {2{wdata[15:0]}};
      default: e_dat = wdata;
    endcase
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    v = (bus_rd >> (8 * off)) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    if (!ok || berr || we) v = 32'd0;
    r.rdata = use_lit ? lit : v;
    r.err   = !ok || berr;
    if (!ok)           lat = 0;
    else if (delay < 0) lat = 1 + stall;
    else               lat = 2 + stall + delay;
    r.cyc = cyc_cnt + 1 + lat;
    s_stall = stall; s_delay = delay; s_err = berr; s_noack = 0; s_rdata = bus_rd;
    stb_seen = 0;
    req_addr_i = addr; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_wdata_i = wdata; req_valid_i = 1'b1;
    exp_q.push_back(r);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i = $urandom; req_wdata_i = $urandom; req_we_i = 1'($urandom);
    req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin @(negedge clk_i); guard++; end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=no_rsp required=rsp addr=%h", addr);
      recover();
    end else begin
      check("stb_cycles", 32'(stb_seen), ok ? 32'(stall + 1) : 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    repeat (3) @(negedge clk_i);
    check("rst_cyc", {31'b0, cyc_o}, 32'd0);
    check("rst_stb", {31'b0, stb_o}, 32'd0);
    check("rst_we", {31'b0, we_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    check("rst_bus", {adr_o, 2'b00} | {28'b0, sel_o} | dat_o | rsp_rdata_o, 32'd0);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    rst_ni = 1'b1;

    // addr, we, size, uns, wdata, bus_rd, stall, delay, berr, use_lit, lit
    issue(32'h103, 1, 0, 0, 32'h0000_00AB, 32'h0, 0, 0, 0, 1, 32'h0);
    issue(32'h102, 0, 1, 0, 32'h0, 32'h8001_1234, 0, 0, 0, 1, 32'hFFFF_8001);
    issue(32'h102, 0, 1, 1, 32'h0, 32'h8001_1234, 0, 0, 0, 1, 32'h0000_8001);
    issue(32'h100, 0, 2, 0, 32'h0, 32'h8001_1234, 3, 0, 0, 1, 32'h8001_1234);
    issue(32'h102, 0, 2, 0, 32'h0, 32'h8001_1234, 0, 0, 0, 1, 32'h0);
    issue(32'h104, 0, 2, 0, 32'h0, 32'h8001_1234, 0, 1, 1, 1, 32'h0);
    issue(32'h101, 0, 0, 0, 32'h0, 32'h0000_F000, 0, -1, 0, 1, 32'hFFFF_FFF0);
    issue(32'h100, 0, 3, 0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
    issue(32'h106, 1, 1, 0, 32'h1234_BEEF, 32'h0, 2, -1, 1, 1, 32'h0);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      issue(a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 1,
            ($urandom_range(0, 7) == 0), 0, 32'h0);
    end

    // Slave never answers: cycle must hold, then reset drops it without a response.
    repeat (2) @(negedge clk_i);
    bus_exp = 1; e_adr = 30'h80; e_sel = 4'hF; e_we = 1'b0; e_dat = 32'h5A5A_5A5A;
    s_noack = 1; s_stall = 0; s_delay = 0; s_err = 0;
    req_addr_i = 32'h200; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_wdata_i = 32'h5A5A_5A5A; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("hold_cyc", {31'b0, cyc_o}, 32'd1);
    check("hold_stb", {31'b0, stb_o}, 32'd0);
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst_cyc", {31'b0, cyc_o}, 32'd0);
    check("async_rst_stb", {31'b0, stb_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    s_noack = 0; bus_exp = 0;
    repeat (6) @(negedge clk_i);
    check("post_rst_ready", {31'b0, req_ready_o}, 32'd1);

`ifdef WB_MASTER_TIMEOUT_EN
    begin
      rsp_t r;
      int   guard;
      bus_exp = 1; s_noack = 1; s_stall = 1;
      r.rdata = 32'h0; r.err = 1'b1; r.cyc = cyc_cnt + 1 + TimeoutCycles;
      req_valid_i = 1'b1;
      exp_q.push_back(r);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin @(negedge clk_i); guard++; end
      check("timeout_rsp_seen", exp_q.size(), 32'd0);
      check("timeout_cyc", {31'b0, cyc_o}, 32'd0);
      s_noack = 0; bus_exp = 0;
      exp_q.delete();
    end
`endif

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
